// File: rtl/gate_chk_pkg.sv
// Shared types and constants for the gate checker: FSM states, vector count,
// error counter width and the expected {AND, OR, NOT a} table.
package gate_chk_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_e;

    localparam int NUM_VECTORS = 4;
    localparam int ERR_CNT_W   = 4;

    // Indexed by {a,b}: 00->001, 01->011, 10->010, 11->110.
    localparam logic [11:0] EXP_TABLE = {3'b110, 3'b010, 3'b011, 3'b001};

    function automatic logic [2:0] expected_for(input logic [1:0] vec);
        return EXP_TABLE[3*vec +: 3];
    endfunction

endpackage

// File: rtl/gate_ref_model.sv
// Combinational reference for the gate block: maps the driven {a,b} to the
// 3-bit response a healthy block must produce.
module gate_ref_model
    import gate_chk_pkg::*;
(
    input  logic [1:0] vec,
    output logic [2:0] expected
);

    assign expected = expected_for(vec);

endmodule

// File: rtl/gate_checker.sv
// Sweeps all four {a,b} vectors through an external gate block and grades y.
// Optional macro GATE_CHK_LOOP_EN makes the sweep repeat forever after start.
module gate_checker
    import gate_chk_pkg::*;
#(
    parameter int HOLD_CYCLES = 50
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 a,
    output logic                 b,
    input  logic [2:0]           y,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic [1:0]           err_vec,
    output logic                 err_valid
);

    localparam logic [7:0]           HOLD_LAST = 8'(HOLD_CYCLES - 2);
    localparam logic [1:0]           LAST_VEC  = 2'(NUM_VECTORS - 1);
    localparam logic [ERR_CNT_W-1:0] ERR_MAX   = '1;

    state_e               state_q, state_d;
    logic [1:0]           idx_q, idx_d;
    logic [7:0]           hold_q, hold_d;
    logic                 a_q, a_d, b_q, b_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 pass_q, pass_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [1:0]           err_vec_q, err_vec_d;
    logic                 err_valid_q, err_valid_d;
    logic [2:0]           expected;
    logic                 mismatch;
    logic                 begin_sweep;

    gate_ref_model u_ref_model (
        .vec      ({a_q, b_q}),
        .expected (expected)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        hold_d      = hold_q;
        done_d      = done_q;
        pass_d      = pass_q;
        err_cnt_d   = err_cnt_q;
        err_vec_d   = err_vec_q;
        err_valid_d = err_valid_q;
        begin_sweep = 1'b0;
        mismatch    = (state_q == SAMPLE) && (y != expected);

        case (state_q)
            IDLE: begin
                if (start) begin
                    begin_sweep = 1'b1;
                end
            end
            DRIVE: begin
                if (hold_q == HOLD_LAST) begin
                    state_d = SAMPLE;
                    hold_d  = 8'd0;
                end else begin
                    hold_d = hold_q + 8'd1;
                end
            end
            SAMPLE: begin
                if (mismatch) begin
                    if (err_cnt_q != ERR_MAX) begin
                        err_cnt_d = err_cnt_q + 1'b1;
                    end
                    if (!err_valid_q) begin
                        err_vec_d   = idx_q;
                        err_valid_d = 1'b1;
                    end
                end
                if (idx_q == LAST_VEC) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    pass_d  = (err_cnt_d == '0);
                end else begin
                    state_d = DRIVE;
                    idx_d   = idx_q + 2'd1;
                end
            end
            DONE: begin
`ifdef GATE_CHK_LOOP_EN
                begin_sweep = 1'b1;
`else
                if (start) begin
                    begin_sweep = 1'b1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase

        // In loop mode the error count spans every sweep since reset.
        if (begin_sweep) begin
            state_d     = DRIVE;
            idx_d       = 2'd0;
            hold_d      = 8'd0;
            done_d      = 1'b0;
            pass_d      = 1'b0;
            err_vec_d   = 2'd0;
            err_valid_d = 1'b0;
`ifndef GATE_CHK_LOOP_EN
            err_cnt_d   = '0;
`endif
        end

`ifdef GATE_CHK_LOOP_EN
        busy_d = (state_d != IDLE);
`else
        busy_d = (state_d == DRIVE) || (state_d == SAMPLE);
`endif
        if ((state_d == DRIVE) || (state_d == SAMPLE)) begin
            {a_d, b_d} = idx_d;
        end else begin
            {a_d, b_d} = 2'b00;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= 2'd0;
            hold_q      <= 8'd0;
            a_q         <= 1'b0;
            b_q         <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_cnt_q   <= '0;
            err_vec_q   <= 2'd0;
            err_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            hold_q      <= hold_d;
            a_q         <= a_d;
            b_q         <= b_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            err_cnt_q   <= err_cnt_d;
            err_vec_q   <= err_vec_d;
            err_valid_q <= err_valid_d;
        end
    end

    assign a         = a_q;
    assign b         = b_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_cnt   = err_cnt_q;
    assign err_vec   = err_vec_q;
    assign err_valid = err_valid_q;

endmodule

// File: tb/tb_gate_checker.sv
// Bench for gate_checker with HOLD_CYCLES=4; a timeline model predicts every
// output from the cycles elapsed since the captured start pulse.
module tb_gate_checker;

    localparam int HOLD   = 4;
    localparam int SWEEP  = 4 * HOLD;
    localparam int PERIOD = SWEEP + 1;

    localparam int FAULT_NONE      = 0;
    localparam int FAULT_AND_LOW   = 1;
    localparam int FAULT_ALL_ONES  = 2;
    localparam int FAULT_ALL_ZEROS = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       a, b;
    logic [2:0] y;
    logic       busy, done, pass;
    logic [3:0] err_cnt;
    logic [1:0] err_vec;
    logic       err_valid;

    int fault_mode = FAULT_NONE;
    int cyc = 0;
    bit active = 1'b0;
    int cap = 0;
    bit check_en = 1'b0;
    int checks = 0;
    int errors = 0;

    int k, r, sweeps, n_sampled, total, first;
    int e_a, e_b, e_busy, e_done, e_pass, e_cnt, e_vec, e_valid;

    gate_checker #(.HOLD_CYCLES(HOLD)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .a         (a),
        .b         (b),
        .y         (y),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .err_cnt   (err_cnt),
        .err_vec   (err_vec),
        .err_valid (err_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] golden(input int v);
        bit ai, bi;
        ai = v[1];
        bi = v[0];
        return {ai & bi, ai | bi, ~ai};
    endfunction

    function automatic logic [2:0] gate_response(input int mode, input int v);
        case (mode)
            FAULT_NONE:     return golden(v);
            FAULT_AND_LOW:  return golden(v) & 3'b011;
            FAULT_ALL_ONES: return 3'b111;
            default:        return 3'b000;
        endcase
    endfunction

    function automatic int mismatches_below(input int n);
        int cnt;
        cnt = 0;
        for (int v = 0; v < n; v++) begin
            if (gate_response(fault_mode, v) != golden(v)) cnt++;
        end
        return cnt;
    endfunction

    function automatic int first_fail_below(input int n);
        for (int v = 0; v < n; v++) begin
            if (gate_response(fault_mode, v) != golden(v)) return v;
        end
        return -1;
    endfunction

    always_comb y = gate_response(fault_mode, int'({a, b}));

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Track which edge captured start; later starts only count from IDLE or a held DONE.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rst) begin
            active = 1'b0;
        end else if (start) begin
            if (!active) begin
                active = 1'b1;
                cap    = cyc;
            end
`ifndef GATE_CHK_LOOP_EN
            else if ((cyc - 1) - cap >= SWEEP) begin
                cap = cyc;
            end
`endif
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            e_a = 0; e_b = 0; e_busy = 0; e_done = 0; e_pass = 0;
            e_cnt = 0; e_vec = 0; e_valid = 0;
            if (!rst && active) begin
                k = cyc - cap;
`ifdef GATE_CHK_LOOP_EN
                sweeps = k / PERIOD;
                r      = k % PERIOD;
                e_busy = 1;
                if (r == SWEEP) begin
                    n_sampled = 4;
                    e_done    = 1;
                end else begin
                    n_sampled = r / HOLD;
                    e_a       = (r / HOLD) / 2;
                    e_b       = (r / HOLD) % 2;
                end
                total  = sweeps * mismatches_below(4) + mismatches_below(n_sampled);
                e_pass = e_done && (total == 0);
`else
                if (k >= SWEEP) begin
                    n_sampled = 4;
                    e_done    = 1;
                end else begin
                    n_sampled = k / HOLD;
                    e_busy    = 1;
                    e_a       = (k / HOLD) / 2;
                    e_b       = (k / HOLD) % 2;
                end
                total  = mismatches_below(n_sampled);
                e_pass = e_done && (total == 0);
`endif
                e_cnt   = (total > 15) ? 15 : total;
                first   = first_fail_below(n_sampled);
                e_valid = (first >= 0) ? 1 : 0;
                e_vec   = (first >= 0) ? first : 0;
            end
            checkOutput("a", a, e_a);
            checkOutput("b", b, e_b);
            checkOutput("busy", busy, e_busy);
            checkOutput("done", done, e_done);
            checkOutput("pass", pass, e_pass);
            checkOutput("err_cnt", err_cnt, e_cnt);
            checkOutput("err_vec", err_vec, e_vec);
            checkOutput("err_valid", err_valid, e_valid);
        end
    end

    task automatic applyStimulus(input int fault, output int start_cyc);
        @(negedge clk);
        #1;
        fault_mode = fault;
        start      = 1'b1;
        start_cyc  = cyc;
        @(negedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic waitDone(output int done_cyc);
        done_cyc = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                done_cyc = cyc;
                break;
            end
        end
        if (done_cyc < 0) checkOutput("done_timeout", 0, 1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int s, d, seen;
        int pulses[$];
        #1;
        rst      = 1'b1;
        check_en = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_err_cnt", err_cnt, 0);
        checkOutput("reset_ab", int'({a, b}), 0);
        #1;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("idle_needs_start", busy, 0);

`ifdef GATE_CHK_LOOP_EN
        applyStimulus(FAULT_ALL_ZEROS, s);
        for (int i = 0; i < 6 * PERIOD + 5; i++) begin
            @(negedge clk);
            if (done === 1'b1) pulses.push_back(cyc);
        end
        checkOutput("loop_pulse_count", pulses.size(), 6);
        if (pulses.size() > 0) checkOutput("loop_first_done", pulses[0] - s, 17);
        for (int i = 1; i < pulses.size(); i++) begin
            checkOutput("loop_pulse_spacing", pulses[i] - pulses[i-1], 17);
        end
        checkOutput("loop_err_cnt_sat", err_cnt, 15);
        checkOutput("loop_busy", busy, 1);
`else
        applyStimulus(FAULT_NONE, s);
        waitDone(d);
        checkOutput("good_latency", d - s, 17);
        checkOutput("good_pass", pass, 1);
        checkOutput("good_err_cnt", err_cnt, 0);
        checkOutput("good_err_valid", err_valid, 0);

        applyStimulus(FAULT_AND_LOW, s);
        waitDone(d);
        checkOutput("and_low_latency", d - s, 17);
        checkOutput("and_low_err_cnt", err_cnt, 1);
        checkOutput("and_low_err_vec", err_vec, 3);
        checkOutput("and_low_err_valid", err_valid, 1);
        checkOutput("and_low_pass", pass, 0);

        applyStimulus(FAULT_ALL_ONES, s);
        waitDone(d);
        checkOutput("ones_err_cnt", err_cnt, 4);
        checkOutput("ones_err_vec", err_vec, 0);
        checkOutput("ones_pass", pass, 0);
        repeat (5) @(negedge clk);
        checkOutput("done_held", done, 1);

        applyStimulus(FAULT_ALL_ONES, s);
        repeat (5) @(negedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midreset_busy", busy, 0);
        checkOutput("midreset_err_cnt", err_cnt, 0);
        checkOutput("midreset_err_valid", err_valid, 0);
        #1;
        rst  = 1'b0;
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        checkOutput("midreset_stays_idle", seen, 0);

        applyStimulus(FAULT_NONE, s);
        repeat (3) @(negedge clk);
        #1;
        start = 1'b1;
        @(negedge clk);
        #1;
        start = 1'b0;
        waitDone(d);
        checkOutput("repulse_latency", d - s, 17);
        checkOutput("repulse_pass", pass, 1);
        checkOutput("repulse_err_cnt", err_cnt, 0);
`endif
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
